// File: rtl/sdrc_tg_pkg.sv
// Shared types and helpers for the SDRAM Wishbone traffic generator:
// FSM state encoding, Wishbone cycle-type codes and burst-length clamping.
package sdrc_tg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_WR_BURST,
        ST_WR_GAP,
        ST_RD_BURST,
        ST_RD_GAP,
        ST_DONE
    } tg_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int MAX_BL_DEFAULT = 8;

    // A zero length still moves one beat; oversize requests fold to the maximum.
    function automatic logic [3:0] clamp_bl(input logic [3:0] len, input logic [3:0] max_bl);
        if (len == 4'd0)  return 4'd1;
        if (len > max_bl) return max_bl;
        return len;
    endfunction

    function automatic logic [2:0] cti_for(input logic [3:0] beat, input logic [3:0] blen);
        if (blen == 4'd1)          return CTI_CLASSIC;
        if (beat == blen - 4'd1)   return CTI_EOB;
        return CTI_INCR;
    endfunction

endpackage

// File: rtl/sdrc_tg_watchdog.sv
// Bus watchdog: counts stalled strobe cycles and flags the cycle on which
// the stall reaches 2^TMO_W-1 consecutive cycles without an acknowledge.
module sdrc_tg_watchdog #(
    parameter int TMO_W = 8
) (
    input  logic sys_clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // Count value seen during the final (2^TMO_W-1)th stalled cycle.
    localparam logic [TMO_W-1:0] TC_VAL = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [TMO_W-1:0] count_q;
    logic [TMO_W-1:0] count_d;

    always_comb begin
        // NOTE: the hold value is assigned first so no branch can leave count_d unassigned and infer a latch.
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + TMO_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge resetn) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = en && (count_q == TC_VAL);

endmodule

// File: rtl/sdrc_wb_traffic_gen.sv
// Wishbone burst master that writes a seed-derived pattern to SDRAM, reads it
// back and reports pass/fail, error count, first failing address and timeouts.
module sdrc_wb_traffic_gen
    import sdrc_tg_pkg::*;
#(
    parameter int APP_AW = 26,
    parameter int DW     = 32,
    parameter int MAX_BL = MAX_BL_DEFAULT,
    parameter int TMO_W  = 8
) (
    input  logic              sys_clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [APP_AW-1:0] cfg_base_addr,
    input  logic [15:0]       cfg_num_bursts,
    input  logic [3:0]        cfg_burst_len,
    input  logic [DW-1:0]     cfg_seed,
    input  logic              sdr_init_done,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [APP_AW-1:0] first_err_addr
);

    localparam logic [3:0] MAX_BL_L = 4'(MAX_BL);

    tg_state_e         state_q, state_d;
    logic [APP_AW-1:0] base_q, base_d;
    logic [15:0]       nbursts_q, nbursts_d;
    logic [3:0]        blen_q, blen_d;
    logic [DW-1:0]     seed_q, seed_d;
    logic [3:0]        beat_q, beat_d;
    logic [15:0]       burst_q, burst_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [APP_AW-1:0] addr_q, addr_d;
    logic [DW-1:0]     dat_q, dat_d;
    logic [DW/8-1:0]   sel_q, sel_d;
    logic [2:0]        cti_q, cti_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [15:0]       err_count_q, err_count_d;
    logic [APP_AW-1:0] first_err_addr_q, first_err_addr_d;

    logic ack_hit;
    logic wd_tc;

    assign ack_hit = stb_q && wb_ack_i;

    sdrc_tg_watchdog #(
        .TMO_W (TMO_W)
    ) u_watchdog (
        .sys_clk (sys_clk),
        .resetn  (resetn),
        .clr     (!stb_q || wb_ack_i),
        .en      (stb_q && !wb_ack_i),
        .tc      (wd_tc)
    );

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        nbursts_d        = nbursts_q;
        blen_d           = blen_q;
        seed_d           = seed_q;
        beat_d           = beat_q;
        burst_d          = burst_q;
        cyc_d            = cyc_q;
        stb_d            = stb_q;
        we_d             = we_q;
        addr_d           = addr_q;
        dat_d            = dat_q;
        cti_d            = cti_q;
        busy_d           = busy_q;
        done_d           = done_q;
        pass_d           = pass_q;
        timeout_d        = timeout_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE) begin
                    done_d = 1'b1;
                    pass_d = (err_count_q == 16'd0) && !timeout_q;
                end
                if (start) begin
                    base_d           = cfg_base_addr;
                    nbursts_d        = cfg_num_bursts;
                    blen_d           = clamp_bl(cfg_burst_len, MAX_BL_L);
                    seed_d           = cfg_seed;
                    beat_d           = 4'd0;
                    burst_d          = 16'd0;
                    err_count_d      = 16'd0;
                    first_err_addr_d = '0;
                    timeout_d        = 1'b0;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                    if (cfg_num_bursts == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_INIT;
                        busy_d  = 1'b1;
                    end
                end
            end

            ST_WAIT_INIT: begin
                if (sdr_init_done) begin
                    state_d = ST_WR_BURST;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = base_q;
                    dat_d   = seed_q;
                    cti_d   = cti_for(4'd0, blen_q);
                end
            end

            ST_WR_BURST, ST_RD_BURST: begin
                if (wd_tc) begin
                    state_d   = ST_DONE;
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    busy_d    = 1'b0;
                end else if (ack_hit) begin
                    // Address and pattern always track base/seed plus the global beat index.
                    addr_d = addr_q + APP_AW'(1);
                    dat_d  = dat_q + DW'(1);
                    if ((state_q == ST_RD_BURST) && (wb_dat_i != dat_q)) begin
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                        if (err_count_q == 16'd0) begin
                            first_err_addr_d = addr_q;
                        end
                    end
                    if (beat_q == blen_q - 4'd1) begin
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        beat_d  = 4'd0;
                        burst_d = burst_q + 16'd1;
                        if (state_q == ST_WR_BURST) begin
                            state_d = ST_WR_GAP;
                        end else if (burst_q == nbursts_q - 16'd1) begin
                            state_d = ST_DONE;
                            we_d    = 1'b0;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = ST_RD_GAP;
                        end
                    end else begin
                        beat_d = beat_q + 4'd1;
                        cti_d  = cti_for(beat_q + 4'd1, blen_q);
                    end
                end
            end

            ST_WR_GAP: begin
                cyc_d = 1'b1;
                stb_d = 1'b1;
                cti_d = cti_for(4'd0, blen_q);
                if (burst_q == nbursts_q) begin
                    state_d = ST_RD_BURST;
                    we_d    = 1'b0;
                    burst_d = 16'd0;
                    addr_d  = base_q;
                    dat_d   = seed_q;
                end else begin
                    state_d = ST_WR_BURST;
                end
            end

            ST_RD_GAP: begin
                state_d = ST_RD_BURST;
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                cti_d   = cti_for(4'd0, blen_q);
            end

            default: state_d = ST_IDLE;
        endcase

        sel_d = stb_d ? '1 : '0;
    end

    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= ST_IDLE;
            base_q           <= '0;
            nbursts_q        <= 16'd0;
            blen_q           <= 4'd1;
            seed_q           <= '0;
            beat_q           <= 4'd0;
            burst_q          <= 16'd0;
            cyc_q            <= 1'b0;
            stb_q            <= 1'b0;
            we_q             <= 1'b0;
            addr_q           <= '0;
            dat_q            <= '0;
            sel_q            <= '0;
            cti_q            <= CTI_CLASSIC;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
            err_count_q      <= 16'd0;
            first_err_addr_q <= '0;
        end else begin
            state_q          <= state_d;
            base_q           <= base_d;
            nbursts_q        <= nbursts_d;
            blen_q           <= blen_d;
            seed_q           <= seed_d;
            beat_q           <= beat_d;
            burst_q          <= burst_d;
            cyc_q            <= cyc_d;
            stb_q            <= stb_d;
            we_q             <= we_d;
            addr_q           <= addr_d;
            dat_q            <= dat_d;
            sel_q            <= sel_d;
            cti_q            <= cti_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            timeout_q        <= timeout_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
        end
    end

    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = stb_q;
    assign wb_we_o        = we_q;
    assign wb_addr_o      = addr_q;
    assign wb_dat_o       = dat_q;
    assign wb_sel_o       = sel_q;
    assign wb_cti_o       = cti_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;

endmodule

// File: doc/sdrc_wb_traffic_gen.md
# sdrc_wb_traffic_gen

Self-checking Wishbone burst master upstream of the SDRAM controller's Wishbone slave port. It waits for SDRAM init, writes a programmable number of incrementing-address bursts with a seed-derived data pattern, reads the same region back and compares each beat. It reports pass/fail, the error count, the first failing address and bus timeouts. It replaces behavioural bus-functional stimulus in system-level and FPGA bring-up runs.

## Interface
- APP_AW, 26, Wishbone word-address width
- DW, 32, Wishbone data width
- MAX_BL, 8, maximum beats per burst
- TMO_W, 8, watchdog counter width; timeout after 2^TMO_W-1 cycles without ack
- sys_clk  in  1  Wishbone/system clock; all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; sampled only in IDLE or DONE
- cfg_base_addr  in  APP_AW  first word address
- cfg_num_bursts  in  16  bursts per phase
- cfg_burst_len  in  4  beats per burst; 0 is treated as 1, values >MAX_BL as MAX_BL
- cfg_seed  in  DW  pattern seed
- sdr_init_done  in  1  controller init complete
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone cycle, strobe, write enable
- wb_addr_o  out  APP_AW  word address
- wb_dat_o  out  DW  write data
- wb_sel_o  out  DW/8  byte selects; all ones when stb is high
- wb_cti_o  out  3  cycle type
- wb_ack_i  in  1  slave acknowledge
- wb_dat_i  in  DW  read data
- busy, done, pass, timeout  out  1  status
- err_count  out  16  saturating mismatch count
- first_err_addr  out  APP_AW  address of the first mismatch

## Operation
- States: IDLE, WAIT_INIT, WR_BURST, WR_GAP, RD_BURST, RD_GAP, DONE.
- On start, config is latched. err_count, first_err_addr, timeout and done are cleared. Next state is WAIT_INIT, or DONE with pass=1 if cfg_num_bursts==0.
- WAIT_INIT → WR_BURST once sdr_init_done=1. Address pointer = base, beat index = 0.
- Each beat drives:
  - wb_addr_o = base + global beat index, mod 2^APP_AW.
  - Expected/write data = cfg_seed + global beat index, mod 2^DW.
- CTI:
  - burst length 1: 3'b000.
  - otherwise: 3'b010 on every beat except the last, which uses 3'b111.
- After the last beat of a burst, go to WR_GAP (or RD_GAP) for exactly one cycle with cyc=stb=0, then start the next burst.
- After the final write burst, WR_GAP → RD_BURST, with address and beat index reset to base/0.
- During reads, each ack compares wb_dat_i against the expected value. On mismatch:
  - err_count increments, saturating at 16'hFFFF.
  - first_err_addr is captured only when err_count was 0.
- After the final read burst, go to DONE.
- DONE: done=1; pass=(err_count==0 && !timeout); held until the next start.
- Watchdog: counts cycles while stb=1 and ack=0, and clears on ack. At terminal count, drop cyc/stb, set timeout=1, pass=0, and go to DONE.
- start while busy is ignored.
- sdr_init_done falling mid-run has no effect.

## Timing
- All outputs are registered.
- Reset values:
  - wb_cyc/stb/we = 0; addr, dat, cti, err_count, first_err_addr = 0; wb_sel_o = 0.
  - busy, done, pass, timeout = 0; state = IDLE.
- busy=1 from the cycle after start until DONE is entered.
- First stb is one cycle after sdr_init_done is sampled high in WAIT_INIT.
- Beat advances on the edge where stb&&ack is sampled. The next beat's address and data are valid the following cycle, so back-to-back acks give one beat per cycle.
- cyc and stb rise and fall together; we is constant within a burst.
- Read compare and err_count update take effect the cycle after the ack.
- Asserting resetn low at any time forces the reset values immediately (asynchronous). An in-flight burst is abandoned.

## Structure
- Package sdrc_tg_pkg: state enum, CTI constants (CTI_CLASSIC, CTI_INCR, CTI_EOB), MAX_BL default, burst-length clamp function.
- One sub-module, sdrc_tg_watchdog: TMO_W counter with clear/enable inputs and a terminal-count output.

## Test plan
- Base 0x100, 2 bursts, len 4, seed 0xA5A50000, slave acks every cycle:
  - writes to 0x100–0x107 with data 0xA5A50000–0xA5A50007.
  - CTI pattern 010,010,010,111; one idle cycle between bursts.
  - done=1, pass=1.
- Same config, slave corrupts read at 0x105 and 0x106 → err_count=2, first_err_addr=0x105, pass=0.
- cfg_num_bursts=0 → done=1 and pass=1 two cycles after start; no cyc activity.
- cfg_burst_len=1 → cti=000 on every beat. cfg_burst_len=12 → clamped to 8-beat bursts.
- Slave withholds ack on first write → cyc drops after 255 cycles; timeout=1, pass=0, done=1.
- Base 0x3FFFFFE, len 4, plus a reset pulse mid read phase:
  - addresses wrap to 0x0000000, 0x0000001.
  - reset clears all outputs asynchronously.
  - a new start reruns cleanly.
